// File: rtl/osd_text_renderer.sv
// osd_text_renderer: menu overlay pixel generator.
// Walks a 32x28 character buffer in the menu BRAM, fetches glyph rows and
// blends 8x8 text cells over the video stream. Video leaves 9 cycles late.
module osd_text_renderer #(
  parameter int          OSD_X     = 256,
  parameter int          OSD_Y     = 128,
  parameter logic [10:0] FONT_BASE = 11'h400,
  parameter logic [23:0] FG_RGB    = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        osd_en,
  input  logic [10:0] in_x,
  input  logic [10:0] in_y,
  input  logic        in_de,
  input  logic        in_hs,
  input  logic        in_vs,
  input  logic [23:0] in_rgb,
  output logic [10:0] mem_addr,
  output logic        mem_ce,
  input  logic [7:0]  mem_dout,
  output logic        out_de,
  output logic        out_hs,
  output logic        out_vs,
  output logic [23:0] out_rgb
);
  localparam int STAGES = 9;          // total video latency
  localparam int OSTG   = STAGES - 1; // stage where the pixel is looked up

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } sync_t;

  logic               frame_on, vs_q;
  logic [10:0]        wx, wy;
  logic               in_win;
  logic [2:0]         phase;
  logic [10:0]        text_addr, font_addr, addr_q;
  logic               code_inv, pend_inv, inv_q;
  logic [7:0]         pend_bits, shift_q;
  sync_t              in_sync;

  sync_t [STAGES:1]     sync_pipe;
  logic  [OSTG:1]       vld_pipe;   // in-window flag
  logic  [OSTG:1][2:0]  phase_pipe;
  logic  [OSTG:1][23:0] rgb_pipe;

  // Window test; an x/y below the origin wraps to a large value and fails
  // the range compare, so no separate underflow check is needed.
  assign wx        = in_x - 11'(OSD_X);
  assign wy        = in_y - 11'(OSD_Y);
  assign in_win    = in_de & frame_on & (wx < 11'd256) & (wy < 11'd224);
  assign phase     = wx[2:0];
  assign text_addr = {1'b0, wy[7:3], wx[7:3]};
  assign font_addr = FONT_BASE + {1'b0, mem_dout[6:0], wy[2:0]};
  assign in_sync   = '{de: in_de, hs: in_hs, vs: in_vs};

  // Memory port: text read at phase 0, glyph read at phase 1 using the code
  // straight off the BRAM output; otherwise the port idles on its last address.
  always_comb begin
    mem_ce   = 1'b0;
    mem_addr = addr_q;
    if (in_win) begin
      if (phase == 3'd0) begin
        mem_ce   = 1'b1;
        mem_addr = text_addr;
      end else if (phase == 3'd1) begin
        mem_ce   = 1'b1;
        mem_addr = font_addr;
      end
    end
  end

  // Overlay enable is only re-evaluated on the vsync rising edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vs_q     <= 1'b0;
      frame_on <= 1'b0;
    end else begin
      vs_q <= in_vs;
      if (in_vs && !vs_q) frame_on <= osd_en;
    end
  end

  // Fetch side: hold address, capture inverse flag and glyph row per cell.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q    <= '0;
      code_inv  <= 1'b0;
      pend_bits <= '0;
      pend_inv  <= 1'b0;
    end else begin
      addr_q <= mem_addr;
      if (in_win && phase == 3'd1) code_inv <= mem_dout[7];
      if (in_win && phase == 3'd2) begin
        pend_bits <= mem_dout;
        pend_inv  <= code_inv;
      end
    end
  end

  // Delay lines, clocked every cycle regardless of de.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_pipe  <= '0;
      vld_pipe   <= '0;
      phase_pipe <= '0;
      rgb_pipe   <= '0;
    end else begin
      sync_pipe  <= {sync_pipe[STAGES-1:1], in_sync};
      vld_pipe   <= {vld_pipe[OSTG-1:1], in_win};
      phase_pipe <= {phase_pipe[OSTG-1:1], phase};
      rgb_pipe   <= {rgb_pipe[OSTG-1:1], in_rgb};
    end
  end

  logic        d_win, d_de, px_set, cur_inv;
  logic [2:0]  d_phase;
  logic [23:0] d_rgb, d_half;
  logic [7:0]  cur_bits;

  // At delayed phase 0 the shift register is being loaded this cycle, so the
  // pending row is used directly for the first pixel of the cell.
  assign d_win    = vld_pipe[OSTG];
  assign d_de     = sync_pipe[OSTG].de;
  assign d_phase  = phase_pipe[OSTG];
  assign d_rgb    = rgb_pipe[OSTG];
  assign cur_bits = (d_phase == 3'd0) ? pend_bits : shift_q;
  assign cur_inv  = (d_phase == 3'd0) ? pend_inv  : inv_q;
  assign px_set   = cur_bits[d_phase] ^ cur_inv;
  assign d_half   = {1'b0, d_rgb[23:17], 1'b0, d_rgb[15:9], 1'b0, d_rgb[7:1]};

  // Output side: cell shift register and registered blended pixel.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shift_q <= '0;
      inv_q   <= 1'b0;
      out_rgb <= '0;
    end else begin
      if (d_win && d_phase == 3'd0) begin
        shift_q <= pend_bits;
        inv_q   <= pend_inv;
      end
      if (!d_de)      out_rgb <= '0;
      else if (d_win) out_rgb <= px_set ? FG_RGB : d_half;
      else            out_rgb <= d_rgb;
    end
  end

  assign out_de = sync_pipe[STAGES].de;
  assign out_hs = sync_pipe[STAGES].hs;
  assign out_vs = sync_pipe[STAGES].vs;

endmodule

// File: tb/tb_osd_text_renderer.sv
// Bench for osd_text_renderer: directed pixel table, multi-cycle corner
// sequences and random line segments checked against a frame-level model.
module tb_osd_text_renderer;
  localparam int          OSD_X     = 256;
  localparam int          OSD_Y     = 128;
  localparam logic [10:0] FONT_BASE = 11'h400;
  localparam logic [23:0] FG        = 24'hFFFFFF;
  localparam logic [23:0] BG        = 24'h80C0FE;
  localparam logic [23:0] BG_HALF   = 24'h40607F;

  logic        clk = 1'b0, resetn = 1'b1, osd_en = 1'b0;
  logic [10:0] in_x = '0, in_y = '0;
  logic        in_de = 1'b0, in_hs = 1'b0, in_vs = 1'b0;
  logic [23:0] in_rgb = '0;
  logic [10:0] mem_addr;
  logic        mem_ce;
  logic [7:0]  mem_dout = '0;
  logic        out_de, out_hs, out_vs;
  logic [23:0] out_rgb;

  osd_text_renderer #(.OSD_X(OSD_X), .OSD_Y(OSD_Y), .FONT_BASE(FONT_BASE), .FG_RGB(FG)) dut (
    .clk(clk), .resetn(resetn), .osd_en(osd_en), .in_x(in_x), .in_y(in_y),
    .in_de(in_de), .in_hs(in_hs), .in_vs(in_vs), .in_rgb(in_rgb),
    .mem_addr(mem_addr), .mem_ce(mem_ce), .mem_dout(mem_dout),
    .out_de(out_de), .out_hs(out_hs), .out_vs(out_vs), .out_rgb(out_rgb));

  always #5 clk = ~clk;

  logic [7:0] mem [0:2047];
  always @(posedge clk) if (mem_ce) mem_dout <= mem[mem_addr];

  typedef struct {
    logic        de, hs, vs;
    logic [23:0] rgb;
    int          tag;
    logic [23:0] trgb;
  } exp_t;

  typedef struct {
    int          x, y;
    logic [23:0] exp_rgb;
    logic        exp_ce;
    logic [10:0] exp_a0, exp_a1;
  } vec_t;

  exp_t q[$];
  int   n_chk = 0, n_pass = 0;
  logic fo_m = 1'b0, vsp_m = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Frame-level reference: which cell, which glyph bit, which colour.
  function automatic logic [23:0] model_rgb(input int x, input int y, input logic de,
                                            input logic fo, input logic [23:0] rgb);
    int wx, wy;
    logic [7:0] code, glyph;
    logic set;
    wx = x - OSD_X;
    wy = y - OSD_Y;
    if (!de) return 24'h0;
    if (!fo || wx < 0 || wx >= 256 || wy < 0 || wy >= 224) return rgb;
    code  = mem[(wy / 8) * 32 + wx / 8];
    glyph = mem[int'(FONT_BASE) + (code % 128) * 8 + wy % 8];
    set   = glyph[wx % 8] ^ code[7];
    if (set) return FG;
    return {rgb[23:16] >> 1, rgb[15:8] >> 1, rgb[7:0] >> 1};
  endfunction

  // Check the memory port for the inputs now applied, queue the expected
  // output, then advance the frame-enable model.
  task automatic model_cycle(input int tag, input logic [23:0] trgb);
    int x, y, wx, wy, ta;
    logic win;
    logic [7:0] code;
    exp_t e;
    x = int'(in_x); y = int'(in_y);
    wx = x - OSD_X; wy = y - OSD_Y;
    win = in_de && fo_m && wx >= 0 && wx < 256 && wy >= 0 && wy < 224;
    chk("mem_ce", mem_ce, win && (wx % 8) < 2);
    if (win) begin
      ta = (wy / 8) * 32 + wx / 8;
      code = mem[ta];
      if (wx % 8 == 0) chk("addr_text", mem_addr, ta);
      else if (wx % 8 == 1) chk("addr_font", mem_addr, int'(FONT_BASE) + (code % 128) * 8 + wy % 8);
    end
    e.de = in_de; e.hs = in_hs; e.vs = in_vs;
    e.rgb = model_rgb(x, y, in_de, fo_m, in_rgb);
    e.tag = tag; e.trgb = trgb;
    q.push_back(e);
    if (in_vs && !vsp_m) fo_m = osd_en;
    vsp_m = in_vs;
  endtask

  task automatic check_out();
    exp_t e;
    if (!resetn)
      chk("reset_zero", {out_de, out_hs, out_vs, out_rgb, mem_ce, mem_addr}, 64'h0);
    else if (q.size() >= 9) begin
      e = q.pop_front();
      chk("video", {out_de, out_hs, out_vs, out_rgb}, {e.de, e.hs, e.vs, e.rgb});
      if (e.tag >= 0) chk($sformatf("vec%0d_rgb", e.tag), out_rgb, e.trgb);
    end
  endtask

  task automatic step(input int x, input int y, input logic de, input logic hs,
                      input logic vs, input logic [23:0] rgb,
                      input int tag = -1, input logic [23:0] trgb = 24'h0);
    @(negedge clk);
    check_out();
    in_x = 11'(x); in_y = 11'(y); in_de = de; in_hs = hs; in_vs = vs; in_rgb = rgb;
    #1;
    if (resetn) model_cycle(tag, trgb);
  endtask

  task automatic rst_assert();
    resetn = 1'b0;
    q.delete();
    fo_m = 1'b0; vsp_m = 1'b0;
  endtask

  // Outputs keep showing reset zeros until the first post-release input arrives.
  task automatic rst_release();
    exp_t z;
    z = '{de: 1'b0, hs: 1'b0, vs: 1'b0, rgb: 24'h0, tag: -1, trgb: 24'h0};
    resetn = 1'b1;
    repeat (8) q.push_back(z);
    #1;
    model_cycle(-1, 24'h0);
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) step(600, 400, 1'b0, i < 2, 1'b0, 24'($urandom));
  endtask

  task automatic vsync();
    repeat (3) step(0, 0, 1'b0, 1'b0, 1'b1, 24'($urandom));
    repeat (2) step(0, 0, 1'b0, 1'b0, 1'b0, 24'($urandom));
  endtask

  task automatic line(input int y, input int x0, input int ncells);
    for (int c = 0; c < ncells; c++)
      for (int p = 0; p < 8; p++) step(x0 + c * 8 + p, y, 1'b1, 1'b0, 1'b0, 24'($urandom));
    blank(4);
  endtask

  vec_t vt[13];

  initial begin
    int x0, y, nc;

    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
    for (int i = 11'h380; i < 11'h500; i++) mem[i] = 8'h00;
    mem[0] = 8'h41; mem[33] = 8'hC1;
    mem[11'h608] = 8'h0C; mem[11'h609] = 8'h1E;

    vt[0]  = '{256, 129, BG_HALF, 1'b1, 11'h000, 11'h609};
    vt[1]  = '{257, 129, FG,      1'b1, 11'h000, 11'h609};
    vt[2]  = '{260, 129, FG,      1'b1, 11'h000, 11'h609};
    vt[3]  = '{261, 129, BG_HALF, 1'b1, 11'h000, 11'h609};
    vt[4]  = '{263, 129, BG_HALF, 1'b1, 11'h000, 11'h609};
    vt[5]  = '{264, 136, FG,      1'b1, 11'h021, 11'h608};
    vt[6]  = '{266, 136, BG_HALF, 1'b1, 11'h021, 11'h608};
    vt[7]  = '{267, 136, BG_HALF, 1'b1, 11'h021, 11'h608};
    vt[8]  = '{271, 136, FG,      1'b1, 11'h021, 11'h608};
    vt[9]  = '{255, 129, BG,      1'b0, 11'h000, 11'h000};
    vt[10] = '{512, 129, BG,      1'b0, 11'h000, 11'h000};
    vt[11] = '{260, 352, BG,      1'b0, 11'h000, 11'h000};
    vt[12] = '{260, 127, BG,      1'b0, 11'h000, 11'h000};

    // Reset with de toggling: every output stays 0.
    #1 rst_assert();
    for (int i = 0; i < 6; i++) step(100, 50, 1'(i % 2), i % 3 == 0, 1'b0, 24'($urandom));
    rst_release();
    for (int i = 0; i < 14; i++) step(100, 50, i % 3 != 0, i % 4 == 0, 1'b0, 24'($urandom));

    // Directed pixel table.
    osd_en = 1'b1;
    vsync();
    foreach (vt[i]) begin
      x0 = vt[i].x - vt[i].x % 8;
      for (int p = 0; p < 8; p++) begin
        step(x0 + p, vt[i].y, 1'b1, 1'b0, 1'b0, BG, (x0 + p == vt[i].x) ? i : -1, vt[i].exp_rgb);
        if (p == 0) begin
          chk($sformatf("vec%0d_ce", i), mem_ce, vt[i].exp_ce);
          if (vt[i].exp_ce) chk($sformatf("vec%0d_a0", i), mem_addr, vt[i].exp_a0);
        end
        if (p == 1 && vt[i].exp_ce) chk($sformatf("vec%0d_a1", i), mem_addr, vt[i].exp_a1);
      end
      blank(3);
    end

    // osd_en changes only take effect at the next vsync rise.
    osd_en = 1'b0; vsync();
    osd_en = 1'b1; line(129, 256, 2); line(136, 248, 3);
    vsync();        line(129, 256, 2); line(136, 248, 3);
    osd_en = 1'b0; line(129, 256, 2);
    vsync();        line(129, 256, 2);

    // Reset in the middle of the window: passthrough until the next vsync.
    osd_en = 1'b1; vsync();
    for (int p = 0; p < 32; p++) begin
      step(256 + p, 129, 1'b1, 1'b0, 1'b0, 24'($urandom));
      if (p == 11) rst_assert();
      if (p == 14) rst_release();
    end
    blank(4);
    line(130, 256, 4); line(129, 256, 2);
    vsync(); line(129, 256, 4);

    // Random frames and segments around the window edges.
    for (int f = 0; f < 16; f++) begin
      osd_en = 1'($urandom_range(0, 1));
      vsync();
      for (int l = 0; l < int'($urandom_range(3, 6)); l++) begin
        if ($urandom_range(0, 7) == 0) osd_en = ~osd_en;
        case ($urandom_range(0, 7))
          0: y = OSD_Y - 1;
          1: y = OSD_Y;
          2: y = OSD_Y + 223;
          3: y = OSD_Y + 224;
          default: y = OSD_Y + int'($urandom_range(0, 223));
        endcase
        x0 = (OSD_X / 8 - 4 + int'($urandom_range(0, 37))) * 8;
        nc = int'($urandom_range(1, 6));
        line(y, x0, nc);
      end
    end

    blank(12);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
